// File: rtl/btn_debounce_multi.sv
// Multi-channel push-button conditioner: synchroniser, shared tick prescaler, N-sample filter, press/release/hold pulses.
// Optional auto-repeat of the hold pulse is enabled by defining BTN_REPEAT_EN. Release output is named rel (release is reserved).
`timescale 1ns/1ps
module btn_debounce_multi #(
  parameter int CH           = 4,
  parameter int CLK_DIV      = 1250000,
  parameter int STABLE       = 3,
  parameter int HOLD_TICKS   = 40,
  parameter int REPEAT_TICKS = 8,
  parameter int IN_POL       = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] bin,
  output logic [CH-1:0] level,
  output logic [CH-1:0] press,
  output logic [CH-1:0] rel,
  output logic [CH-1:0] hold,
  output logic          tick
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW = (STABLE > 1) ? $clog2(STABLE) : 1;
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [SW-1:0] SCNT_LAST = SW'(STABLE - 1);
  localparam logic [HW-1:0] HCNT_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [HW-1:0] HCNT_SAT  = HW'(HOLD_TICKS);
`ifdef BTN_REPEAT_EN
  localparam logic [HW-1:0] HCNT_RELOAD = HW'(HOLD_TICKS - REPEAT_TICKS);
`else
  localparam logic [HW-1:0] HCNT_RELOAD = HCNT_SAT;
`endif
  localparam logic [CH-1:0] POL = {CH{1'(IN_POL)}};

  if (CH < 1 || CH > 16 || CLK_DIV < 1 || STABLE < 1 || STABLE > 255 ||
      HOLD_TICKS < 1 || REPEAT_TICKS < 1 || IN_POL < 0 || IN_POL > 1) begin : g_param_check
    $error("btn_debounce_multi: parameter out of range");
  end
`ifdef BTN_REPEAT_EN
  if (REPEAT_TICKS > HOLD_TICKS) begin : g_repeat_check
    $error("btn_debounce_multi: REPEAT_TICKS must not exceed HOLD_TICKS");
  end
`endif

  logic [CH-1:0] s1, s2, samp;
  logic [CW-1:0] cnt;
  logic          tick_c;
  logic [SW-1:0] scnt [CH];
  logic [HW-1:0] hcnt [CH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= POL;
      s2 <= POL;
    end else begin
      s1 <= bin;
      s2 <= s1;
    end
  end

  assign samp   = s2 ^ POL;
  assign tick_c = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= tick_c ? '0 : cnt + CW'(1);
      tick <= tick_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level <= '0;
      press <= '0;
      rel   <= '0;
      hold  <= '0;
      for (int unsigned i = 0; i < CH; i++) begin
        scnt[i] <= '0;
        hcnt[i] <= '0;
      end
    end else begin
      press <= '0;
      rel   <= '0;
      hold  <= '0;
      for (int unsigned i = 0; i < CH; i++) begin
        if (!level[i]) begin
          hcnt[i] <= '0;
        end else if (tick_c && hcnt[i] == HCNT_LAST) begin
          hold[i] <= 1'b1;
          hcnt[i] <= HCNT_RELOAD;
        end else if (tick_c && hcnt[i] != HCNT_SAT) begin
          hcnt[i] <= hcnt[i] + HW'(1);
        end
        if (tick_c) begin
          if (samp[i] == level[i]) begin
            scnt[i] <= '0;
          end else if (scnt[i] == SCNT_LAST) begin
            // A level change overrides the hold path above: clears the count, suppresses any hold pulse.
            scnt[i]  <= '0;
            level[i] <= ~level[i];
            press[i] <= ~level[i];
            rel[i]   <= level[i];
            hcnt[i]  <= '0;
            hold[i]  <= 1'b0;
          end else begin
            scnt[i] <= scnt[i] + SW'(1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_btn_debounce_multi.sv
// Self-checking bench for btn_debounce_multi: tick-level behavioural model plus directed literal checks and random stimulus.
`timescale 1ns/1ps
module tb_btn_debounce_multi;
  localparam int CH      = 2;
  localparam int CLK_DIV = 4;
  localparam int STABLE  = 3;
  localparam int HOLDT   = 5;
  localparam int REPT    = 2;
  localparam int IN_POL  = 0;
`ifdef BTN_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] bin;
  logic [CH-1:0] level, press, rel, hold;
  logic          tick;

  btn_debounce_multi #(
    .CH(CH), .CLK_DIV(CLK_DIV), .STABLE(STABLE),
    .HOLD_TICKS(HOLDT), .REPEAT_TICKS(REPT), .IN_POL(IN_POL)
  ) dut (
    .clk(clk), .rst(rst), .bin(bin), .level(level), .press(press),
    .rel(rel), .hold(hold), .tick(tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: counts edges to find ticks, counts differing ticks, counts ticks since press.
  int ph;
  bit [CH-1:0] d1, d2, m_lvl;
  int run [CH];
  int tsp [CH];
  bit [CH-1:0] e_level, e_press, e_rel, e_hold;
  bit e_tick;

  always @(posedge clk) begin : model
    bit ev;
    bit [CH-1:0] smp;
    if (!rst) begin
      ph = 0; d1 = '0; d2 = '0; m_lvl = '0;
      e_level = '0; e_press = '0; e_rel = '0; e_hold = '0; e_tick = 1'b0;
      for (int c = 0; c < CH; c++) begin run[c] = 0; tsp[c] = 0; end
    end else begin
      smp = (IN_POL != 0) ? ~d2 : d2;
      d2 = d1;
      d1 = bin;
      ph = ph + 1;
      ev = (ph == CLK_DIV);
      if (ev) ph = 0;
      e_press = '0; e_rel = '0; e_hold = '0; e_tick = ev;
      if (ev) begin
        for (int c = 0; c < CH; c++) begin
          if (smp[c] != m_lvl[c]) begin
            run[c] = run[c] + 1;
            if (run[c] == STABLE) begin
              run[c] = 0;
              m_lvl[c] = smp[c];
              if (m_lvl[c]) begin e_press[c] = 1'b1; tsp[c] = 0; end
              else e_rel[c] = 1'b1;
            end
          end else begin
            run[c] = 0;
          end
          if (m_lvl[c] && !e_press[c]) begin
            tsp[c] = tsp[c] + 1;
            if (tsp[c] == HOLDT || (REP && tsp[c] > HOLDT && ((tsp[c] - HOLDT) % REPT) == 0))
              e_hold[c] = 1'b1;
          end
        end
      end
      e_level = m_lvl;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (rst) begin
      check("level", level, e_level);
      check("press", press, e_press);
      check("release", rel, e_rel);
      check("hold", hold, e_hold);
      check("tick", tick, e_tick);
    end
  endtask

  task automatic wait_lvl(input int c, input bit v, output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (level[c] == v) begin lat = k; break; end
    end
  endtask

  task automatic first_tick(output int k0);
    k0 = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (tick) begin k0 = k; break; end
    end
  endtask

  int hidx [8];
  int hn;
  task automatic watch_hold(input int c, input int nt);
    int ti;
    ti = 0; hn = 0;
    for (int k = 0; k < nt * CLK_DIV + 8 && ti < nt; k++) begin
      step();
      if (tick) ti++;
      if (hold[c]) begin
        if (hn < 8) hidx[hn] = ti;
        hn++;
      end
    end
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, k0, p0, p1, h0, h1;
    bit [2:0] seen;
    rst = 1'b0;
    bin = '0;
    repeat (3) step();
    check("rst_outputs", {level, press, rel, hold, tick}, 0);
    rst = 1'b1;
    first_tick(k0);
    check("first_tick_cycles", k0, 4);

    // Clean press on ch0.
    repeat (5) step();
    bin[0] = 1'b1;
    wait_lvl(0, 1'b1, lat);
    check("press_lat_in_range", (lat >= 1 && lat <= 14) ? 1 : 0, 1);
    check("press0_with_level", press[0], 1);
    check("press1_quiet", press[1], 0);
    watch_hold(0, 12);
    check("hold_first_tick", hidx[0], 5);
    if (REP) begin
      check("hold_count_rep", hn, 4);
      check("hold_2nd_tick", hidx[1], 7);
      check("hold_3rd_tick", hidx[2], 9);
      check("hold_4th_tick", hidx[3], 11);
    end else begin
      check("hold_count_single", hn, 1);
    end

    // Glitch on ch1 lasting two ticks.
    seen = '0;
    bin[1] = 1'b1;
    repeat (8) begin step(); seen |= {level[1], press[1], rel[1]}; end
    bin[1] = 1'b0;
    repeat (20) begin step(); seen |= {level[1], press[1], rel[1]}; end
    check("glitch_rejected", seen, 0);

    // Asynchronous reset mid-cycle during an active press.
    check("level0_before_reset", level[0], 1);
    #2 rst = 1'b0;
    #1 check("async_reset_outputs", {level, press, rel, hold, tick}, 0);
    repeat (2) step();
    rst = 1'b1;
    first_tick(k0);
    check("tick_after_reset", k0, 4);
    wait_lvl(0, 1'b1, lat);
    check("repress_after_reset", level[0], 1);

    // Release and re-press.
    repeat (3) step();
    bin[0] = 1'b0;
    wait_lvl(0, 1'b0, lat);
    check("release_lat_in_range", (lat >= 1 && lat <= 14) ? 1 : 0, 1);
    check("release0_pulse", rel[0], 1);
    step();
    check("release0_one_cycle", rel[0], 0);
    repeat (6) step();
    bin[0] = 1'b1;
    wait_lvl(0, 1'b1, lat);
    watch_hold(0, 6);
    check("repress_hold_tick", hidx[0], 5);

    // Simultaneous press on both channels.
    bin = '0;
    wait_lvl(0, 1'b0, lat);
    repeat (16) step();
    bin = 2'b11;
    p0 = -1; p1 = -1;
    for (int k = 1; k <= 40 && (p0 < 0 || p1 < 0); k++) begin
      step();
      if (press[0]) p0 = k;
      if (press[1]) p1 = k;
    end
    check("sim_press_seen", (p0 > 0) ? 1 : 0, 1);
    check("sim_press_same_cycle", p0, p1);
    h0 = -1; h1 = -1;
    for (int k = 1; k <= 60 && (h0 < 0 || h1 < 0); k++) begin
      step();
      if (hold[0] && h0 < 0) h0 = k;
      if (hold[1] && h1 < 0) h1 = k;
    end
    check("sim_hold_seen", (h0 > 0) ? 1 : 0, 1);
    check("sim_hold_same_cycle", h0, h1);

    // Random stimulus, with one mid-run asynchronous reset.
    for (int i = 0; i < 2000; i++) begin
      step();
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 11) == 0) bin[c] = ~bin[c];
      if (i == 1000) begin
        #2 rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/btn_debounce_multi.md
# btn_debounce_multi

Parameterised multi-channel push-button conditioner for the board's user inputs. It synchronises `CH` raw button lines and debounces each on a shared sample tick with an N-sample stability filter. It produces a clean level per channel plus one-clock press, release and long-press (hold) pulses for the control FSMs. It replaces the single-channel 40 Hz sample-and-hold conditioner.

## Interface
Parameters:
- `CH`, default 4: number of button channels, 1..16.
- `CLK_DIV`, default 1250000: `clk` cycles per sample tick (40 Hz at 50 MHz); must be ≥1.
- `STABLE`, default 3: consecutive differing ticks required to change a level, 1..255.
- `HOLD_TICKS`, default 40: ticks of continuous level=1 before the first hold pulse; must be ≥1.
- `REPEAT_TICKS`, default 8: ticks between auto-repeat hold pulses (used only with `BTN_REPEAT_EN`); must be ≥1.
- `IN_POL`, default 0: 0 means a button is pressed when `bin`=1; 1 means pressed when `bin`=0.

Ports:
- `clk` input, 1 bit: system clock.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `bin` input, `CH` bits: raw asynchronous button lines.
- `level` output, `CH` bits: debounced pressed state; 1 means pressed.
- `press` output, `CH` bits: one-`clk` pulse on a debounced 0→1 transition.
- `release` output, `CH` bits: one-`clk` pulse on a debounced 1→0 transition.
- `hold` output, `CH` bits: one-`clk` long-press pulse.
- `tick` output, 1 bit: one-`clk` pulse per sample tick, shared with downstream logic.

## Operation
- **Synchroniser:** 2-FF synchroniser per channel, clocked every `clk`. Reset value is `IN_POL`, so the normalised sample resets to "not pressed". After synchronisation the sample is XORed with `IN_POL`.
- **Prescaler:** counter `cnt` of width `$clog2(CLK_DIV)` (minimum 1 bit) counts 0..`CLK_DIV`-1 and wraps to 0. An internal tick condition is true when `cnt`==`CLK_DIV`-1. With `CLK_DIV`=1 the tick is true every cycle.
- **Stability filter** (per channel, evaluated on tick cycles only):
  - If sample == `level`: `scnt` clears to 0.
  - If sample != `level` and `scnt`==`STABLE`-1: `level` toggles and `scnt` clears.
  - Otherwise `scnt` increments.
  - A glitch shorter than `STABLE` consecutive ticks never changes `level`.
- **Edge pulses:** `press` and `release` are registered and assert in the same edge that updates `level`. They last exactly one `clk` cycle.
- **Hold counter** (per channel, width `$clog2(HOLD_TICKS+1)`):
  - Clears whenever `level` is 0, and in the edge where `level` rises.
  - While `level`=1, increments on each tick.
  - On reaching `HOLD_TICKS`, `hold` pulses once for one `clk`.
  - Without `BTN_REPEAT_EN`, the counter then saturates and produces no further pulses.
- **Same-edge rules:**
  - Each channel is independent; any subset of channels may pulse in the same cycle.
  - `press` and `hold` never coincide on a channel.
  - `release` clears the hold/repeat state in the same edge.
- **Reset:** asserting `rst` low at any time immediately clears `level`, `press`, `release`, `hold`, `tick`, all counters and the synchronisers, with no pending pulse. Operation resumes from the first rising `clk` after `rst` returns high.

## Timing
- Reset value of every output is 0.
- `tick` is registered: high for the one cycle after `cnt` wraps. The first `tick` occurs `CLK_DIV` cycles after reset release.
- Input-to-`level` latency after `bin` settles: 2 `clk` of synchronisation, plus 0..`CLK_DIV`-1 cycles of tick alignment, plus (`STABLE`-1)·`CLK_DIV`, plus 1 registered edge. The worst case is ≤ `STABLE`·`CLK_DIV`+2 cycles.
- `level` and `press`/`release` change on the same edge; the pulses drop on the next edge.
- The first `hold` comes exactly `HOLD_TICKS` ticks after the `press` edge. Repeat pulses come every `REPEAT_TICKS` ticks after that.

## Configuration
- `BTN_REPEAT_EN` defined: after the first hold pulse, the counter reloads to `HOLD_TICKS`-`REPEAT_TICKS`. This yields a further `hold` pulse every `REPEAT_TICKS` ticks while `level`=1. `REPEAT_TICKS` must be ≤ `HOLD_TICKS`.
- `BTN_REPEAT_EN` undefined: exactly one `hold` pulse per press. The reload logic is absent.

## Test plan
All scenarios use `CH`=2, `CLK_DIV`=4, `STABLE`=3, `HOLD_TICKS`=5, `REPEAT_TICKS`=2, `IN_POL`=0.
- **Async reset:** drop `rst` mid-cycle during an active press → `level`=0 and all pulses 0 before the next `clk` edge. The first `tick` comes 4 cycles after release.
- **Clean press:** `bin[0]` 0→1 and held → `level[0]`=1 with a single-cycle `press[0]` on the 3rd tick after synchronisation, within ≤14 `clk`. `press[1]` stays 0.
- **Glitch rejection:** `bin[1]` high for 2 ticks then low → `level[1]`, `press[1]` and `release[1]` stay 0.
- **Hold:** hold ch0 → `hold[0]` pulses 5 ticks after `press[0]`.
  - With `BTN_REPEAT_EN`: further pulses at ticks 7, 9 and 11.
  - Without the macro: no further pulses.
- **Release:** `bin[0]` low for 3 ticks → single `release[0]`, `level[0]`=0. A re-press needs 5 fresh ticks before `hold[0]`.
- **Simultaneous:** `bin[1:0]` 00→11 in the same cycle → `press[0]` and `press[1]` in the same cycle. Later `hold[0]` and `hold[1]` also coincide.
